tick_sched: RTL and testbench

//  Central time-base controller for the alarm clock. It runs three prescalers from the one system clock:
//   - a 1 Hz seconds prescaler, which becomes a fast-advance rate in SET mode;
//   - a display-multiplex strobe;
//   - a blink toggle.
//  A STOP/RUN/SET state machine sequences them. Seconds ticks go to the time counter over a req/ack handshake,
//  and ticks that are not acknowledged are counted as misses.

---
 rtl/tick_sched_pkg.sv | 21 ++
 rtl/pre_cnt.sv | 32 +++
 rtl/tick_sched.sv | 91 +++++++++
 tb/tb_tick_sched.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - state encodings, default divisors and helpers for tick_sched
package tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_SET  = 2'b10
  } state_t;

  localparam int unsigned DEF_SEC_DIV   = 50_000_000;
  localparam int unsigned DEF_FAST_DIV  = 3_125_000;
  localparam int unsigned DEF_MUX_DIV   = 50_000;
  localparam int unsigned DEF_BLINK_DIV = 12_500_000;
  localparam int unsigned DEF_CW        = 32;
  localparam int unsigned MISSED_W      = 4;

  function automatic logic [MISSED_W-1:0] sat_inc(input logic [MISSED_W-1:0] v);
    return (&v) ? v : v + MISSED_W'(1);
  endfunction

endpackage

// File: rtl/pre_cnt.sv
// rtl/pre_cnt.sv - enable/clear prescaler with a combinational one-cycle wrap
module pre_cnt #(
  parameter int unsigned CW = 32
) (
  input  logic          reloje,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] div,
  output logic          wrap
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic          at_top;

  assign at_top = (cnt == div - ONE);
  // clr suppresses the wrap so a restart never emits a stray tick
  assign wrap   = en & ~clr & at_top;

  always_ff @(posedge reloje or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !en || at_top) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/tick_sched.sv
// rtl/tick_sched.sv - STOP/RUN/SET time base with seconds req/ack, mux strobe and blink
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned SEC_DIV   = DEF_SEC_DIV,
  parameter int unsigned FAST_DIV  = DEF_FAST_DIV,
  parameter int unsigned MUX_DIV   = DEF_MUX_DIV,
  parameter int unsigned BLINK_DIV = DEF_BLINK_DIV,
  parameter int unsigned CW        = DEF_CW
) (
  input  logic                reloje,
  input  logic                rst_n,
  input  logic                run_en,
  input  logic                set_mode,
  input  logic                clr,
  input  logic                seg_ack,
  output logic                seg_req,
  output logic                mux_tick,
  output logic                blink,
  output logic [MISSED_W-1:0] missed,
  output logic [1:0]          state
);

  state_t        st_q, st_nxt;
  logic          active, leaving_stop_bound, sec_clr;
  logic          sec_wrap, mux_wrap, blink_wrap;
  logic [CW-1:0] sec_div;

  always_ff @(posedge reloje or negedge rst_n) begin
    if (!rst_n) st_q <= ST_STOP;
    else        st_q <= st_nxt;
  end

  always_comb begin
    st_nxt = st_q;
    if (!run_en) begin
      st_nxt = ST_STOP;
    end else begin
      case (st_q)
        ST_STOP: st_nxt = set_mode ? ST_SET : ST_RUN;
        ST_RUN:  if (set_mode)  st_nxt = ST_SET;
        ST_SET:  if (!set_mode) st_nxt = ST_RUN;
        default: st_nxt = ST_STOP;
      endcase
    end
  end

  assign active             = (st_q != ST_STOP);
  assign leaving_stop_bound = (st_nxt == ST_STOP);
  assign sec_clr            = clr | (st_nxt != st_q);
  assign sec_div            = (st_q == ST_SET) ? CW'(FAST_DIV) : CW'(SEC_DIV);
  assign state              = st_q;

  pre_cnt #(.CW(CW)) u_sec (
    .reloje(reloje), .rst_n(rst_n), .en(active), .clr(sec_clr),
    .div(sec_div), .wrap(sec_wrap)
  );

  pre_cnt #(.CW(CW)) u_mux (
    .reloje(reloje), .rst_n(rst_n), .en(1'b1), .clr(1'b0),
    .div(CW'(MUX_DIV)), .wrap(mux_wrap)
  );

  pre_cnt #(.CW(CW)) u_blink (
    .reloje(reloje), .rst_n(rst_n), .en(active), .clr(1'b0),
    .div(CW'(BLINK_DIV)), .wrap(blink_wrap)
  );

  // a wrap while a tick is still pending and unacked is an overrun
  always_ff @(posedge reloje or negedge rst_n) begin
    if (!rst_n) begin
      seg_req  <= 1'b0;
      missed   <= '0;
      mux_tick <= 1'b0;
      blink    <= 1'b0;
    end else begin
      mux_tick <= mux_wrap;

      if (leaving_stop_bound) seg_req <= 1'b0;
      else if (sec_wrap)      seg_req <= 1'b1;
      else if (seg_ack)       seg_req <= 1'b0;

      if (clr)                                 missed <= '0;
      else if (sec_wrap && seg_req && !seg_ack) missed <= sat_inc(missed);

      if (leaving_stop_bound) blink <= 1'b0;
      else if (blink_wrap)    blink <= ~blink;
    end
  end

endmodule

// File: tb/tb_tick_sched.sv
// tb/tb_tick_sched.sv - directed self-checking bench for tick_sched
module tb_tick_sched;

  logic       reloje, rst_n, run_en, set_mode, clr, seg_ack;
  logic       seg_req, mux_tick, blink;
  logic [3:0] missed;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  tick_sched #(.SEC_DIV(10), .FAST_DIV(3), .MUX_DIV(4), .BLINK_DIV(5), .CW(8)) dut (
    .reloje(reloje), .rst_n(rst_n), .run_en(run_en), .set_mode(set_mode),
    .clr(clr), .seg_ack(seg_ack), .seg_req(seg_req), .mux_tick(mux_tick),
    .blink(blink), .missed(missed), .state(state)
  );

  initial begin
    reloje = 1'b0;
    forever #5 reloje = ~reloje;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one rising edge, then settle before sampling or driving
  task automatic step();
    @(posedge reloje);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; set_mode = 1'b0; clr = 1'b0; seg_ack = 1'b0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_req", seg_req, 0);
    chk("rst_mux", mux_tick, 0);
    chk("rst_blink", blink, 0);
    chk("rst_missed", missed, 0);
    step();
    rst_n = 1'b1;

    // 1: STOP, mux strobes at 4, 8, 12
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("t1_mux", mux_tick, (c % 4 == 0));
      chk("t1_state", state, 0);
      chk("t1_req", seg_req, 0);
      chk("t1_blink", blink, 0);
    end

    // 2: RUN with ack tied high
    seg_ack = 1'b1; run_en = 1'b1;
    step();
    chk("t2_state", state, 1);
    for (int c = 1; c <= 35; c++) begin
      step();
      chk("t2_req", seg_req, (c % 10 == 0));
      chk("t2_blink", blink, (c / 5) % 2);
    end
    chk("t2_missed", missed, 0);
    run_en = 1'b0;
    step();
    chk("t2_stop", state, 0);
    chk("t2_stop_blink", blink, 0);

    // 3 and 5: RUN with ack low, overruns, ack+wrap, clr at wrap
    seg_ack = 1'b0; run_en = 1'b1;
    step();
    for (int c = 1; c <= 35; c++) begin
      step();
      chk("t3_req", seg_req, (c >= 10));
      chk("t3_missed", missed, (c >= 30) ? 2 : (c >= 20) ? 1 : 0);
    end
    seg_ack = 1'b1;
    step();
    chk("t3_ack_drop", seg_req, 0);
    seg_ack = 1'b0;
    repeat (13) step();
    chk("t5_pending", seg_req, 1);
    seg_ack = 1'b1;
    step();
    chk("t5_ackwrap_req", seg_req, 1);
    chk("t5_ackwrap_missed", missed, 2);
    step();
    chk("t5_ack_drop", seg_req, 0);
    seg_ack = 1'b0;
    repeat (8) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_clr_req", seg_req, 0);
    chk("t5_clr_missed", missed, 0);
    repeat (9) step();
    chk("t5_after_clr_9", seg_req, 0);
    step();
    chk("t5_after_clr_10", seg_req, 1);
    run_en = 1'b0;
    step();
    chk("t5_stop_discard", seg_req, 0);
    chk("t5_stop_missed", missed, 0);

    // 4: RUN -> SET mid-second -> RUN
    seg_ack = 1'b1; run_en = 1'b1;
    step();
    repeat (3) step();
    set_mode = 1'b1;
    step();
    chk("t4_set_state", state, 2);
    for (int d = 1; d <= 9; d++) begin
      step();
      chk("t4_fast_req", seg_req, (d % 3 == 0));
    end
    set_mode = 1'b0;
    step();
    chk("t4_run_state", state, 1);
    chk("t4_run_req0", seg_req, 0);
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("t4_run_req", seg_req, (e == 10));
    end

    // 6: async reset mid-RUN with a pending tick and missed=3
    run_en = 1'b0;
    step();
    seg_ack = 1'b0; run_en = 1'b1;
    step();
    repeat (40) step();
    chk("t6_pre_req", seg_req, 1);
    chk("t6_pre_missed", missed, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_state", state, 0);
    chk("t6_req", seg_req, 0);
    chk("t6_missed", missed, 0);
    chk("t6_blink", blink, 0);
    chk("t6_mux", mux_tick, 0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
